// File: rtl/uart_rx_sipo.sv
// UART receive shift register: 16x-oversampled start detection, centre sampling,
// LSB-first deserialization of 7/8 data bits, optional parity and 1/2 stop bits.
module uart_rx_sipo #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       data_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] MidCnt  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e          state_q;
  logic            armed_q;
  logic [CntW-1:0] tick_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic            stop_cnt_q;
  logic [7:0]      shift_q;
  logic [1:0]      par_type_q;
  logic            two_stop_q;
  logic            len8_q;
  logic            par_err_q;
  logic            frm_err_q;
  logic            line_meta_q;
  logic            line_q;

  logic [7:0] rx_data;
  logic       par_en;
  logic       par_odd;
  logic       par_mismatch;
  logic [2:0] last_bit;

  // Bits shift in from the top, so a 7-bit frame ends up one position high.
  always_comb begin
    rx_data      = len8_q ? shift_q : {1'b0, shift_q[7:1]};
    par_en       = (par_type_q == 2'b01) || (par_type_q == 2'b10);
    par_odd      = (par_type_q == 2'b01);
    par_mismatch = (^rx_data) ^ line_q ^ par_odd;
    last_bit     = len8_q ? 3'd7 : 3'd6;
  end

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (rst) begin
      line_meta_q <= 1'b1;
      line_q      <= 1'b1;
    end else begin
      line_meta_q <= data_in;
      line_q      <= line_meta_q;
    end
  end

  // Receive FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= StIdle;
      armed_q      <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_type_q   <= '0;
      two_stop_q   <= 1'b0;
      len8_q       <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      data_out     <= '0;
      rx_active    <= 1'b0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sample_tick) begin
            if (line_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q    <= StStart;
              armed_q    <= 1'b0;
              tick_cnt_q <= '0;
              par_type_q <= parity_type;
              two_stop_q <= stop_bits;
              len8_q     <= data_length;
            end
          end
        end
        StStart: begin
          if (sample_tick) begin
            if (tick_cnt_q == MidCnt) begin
              tick_cnt_q <= '0;
              if (!line_q) begin
                state_q   <= StData;
                rx_active <= 1'b1;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
              end else begin
                // False start: the line already counts as seen high.
                state_q <= StIdle;
                armed_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (sample_tick) begin
            if (tick_cnt_q == LastCnt) begin
              tick_cnt_q <= '0;
              shift_q    <= {line_q, shift_q[7:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == last_bit) begin
                state_q    <= par_en ? StParity : StStop;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (sample_tick) begin
            if (tick_cnt_q == LastCnt) begin
              tick_cnt_q <= '0;
              par_err_q  <= par_mismatch;
              state_q    <= StStop;
              stop_cnt_q <= 1'b0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (sample_tick) begin
            if (tick_cnt_q == LastCnt) begin
              tick_cnt_q <= '0;
              if (!line_q) begin
                frm_err_q <= 1'b1;
              end
              if (stop_cnt_q || !two_stop_q) begin
                state_q <= StDone;
              end else begin
                stop_cnt_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          data_out     <= rx_data;
          parity_error <= par_err_q;
          frame_error  <= frm_err_q;
          rx_done      <= 1'b1;
          rx_active    <= 1'b0;
          // Must see the line high again before another start is accepted.
          armed_q      <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo with an expected-frame scoreboard.
module tb_uart_rx_sipo;

  localparam int BitClks = 256;  // 16 ticks per bit, 16 clocks per tick

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       data_in = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b1;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       frame_error;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         ticks;
    logic       act;
  } rec_t;

  rec_t sb[$];
  rec_t obs[$];

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   done_wide = 0;
  int   active_rises = 0;
  int   act_ticks = 0;
  logic prev_active = 1'b0;
  logic prev_done = 1'b0;

  uart_rx_sipo #(.OVERSAMPLE(16)) dut (
    .clock        (clock),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .data_in      (data_in),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_out     (data_out),
    .rx_active    (rx_active),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .frame_error  (frame_error)
  );

  initial forever #5 clock = ~clock;

  // One-clock tick every 16 clocks, driven on the falling edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clock);
      sample_tick = (div == 15);
      div = (div + 1) % 16;
    end
  end

  // Output monitor: sampled just after each rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    if (sample_tick && prev_active) act_ticks++;
    if (rx_active && !prev_active) begin
      act_ticks = 0;
      active_rises++;
    end
    if (rx_done) begin
      if (prev_done) done_wide++;
      done_cnt++;
      obs.push_back('{data_out, parity_error, frame_error, act_ticks, rx_active});
    end
    prev_active = rx_active;
    prev_done   = rx_done;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic hold(input logic v, input int clks);
    data_in = v;
    repeat (clks) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                      input logic pbit, input logic two, input logic stopv);
    parity_type = pt;
    stop_bits   = two;
    data_length = len8;
    hold(1'b0, BitClks);
    for (int i = 0; i < (len8 ? 8 : 7); i++) hold(d[i], BitClks);
    if (pt == 2'b01 || pt == 2'b10) hold(pbit, BitClks);
    hold(stopv, BitClks);
    if (two) hold(stopv, BitClks);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                              input logic pbit, input logic two, input logic stopv);
    rec_t r;
    int   ones;
    logic pen;
    pen    = (pt == 2'b01) || (pt == 2'b10);
    r.d    = len8 ? d : {1'b0, d[6:0]};
    ones   = $countones(r.d) + (pen ? int'(pbit) : 0);
    r.pe   = (pt == 2'b01) ? (ones % 2 == 0) : (pt == 2'b10) ? (ones % 2 == 1) : 1'b0;
    r.fe   = !stopv;
    r.ticks = 16 * ((len8 ? 8 : 7) + (pen ? 1 : 0) + (two ? 2 : 1));
    r.act  = 1'b0;
    sb.push_back(r);
  endtask

  task automatic check_frame(input string tag);
    rec_t e;
    rec_t o;
    for (int i = 0; i < 2000 && obs.size() == 0; i++) @(negedge clock);
    chk({tag, "_done_seen"}, obs.size(), 1);
    if (obs.size() > 0 && sb.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      chk({tag, "_data"}, o.d, e.d);
      chk({tag, "_perr"}, o.pe, e.pe);
      chk({tag, "_ferr"}, o.fe, e.fe);
      chk({tag, "_active_ticks"}, o.ticks, e.ticks);
      chk({tag, "_active_at_done"}, o.act, e.act);
    end
  endtask

  initial begin
    int dc;
    int ar;
    // Reset state
    repeat (4) @(negedge clock);
    chk("rst_data", data_out, 8'h00);
    chk("rst_active", rx_active, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", frame_error, 0);
    rst = 1'b0;
    hold(1'b1, 2 * BitClks);

    // 8N1 0xA5
    expect_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    send(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    check_frame("f8n1_a5");
    hold(1'b1, BitClks);

    // 8O1 0x4A with wrong, then correct, parity bit
    expect_frame(8'h4A, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    send(8'h4A, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    check_frame("f8o1_bad");
    hold(1'b1, BitClks);
    expect_frame(8'h4A, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    send(8'h4A, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    check_frame("f8o1_good");
    hold(1'b1, BitClks);

    // 7E2 0x55
    expect_frame(8'h55, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
    send(8'h55, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
    check_frame("f7e2_55");
    hold(1'b1, BitClks);

    // 8N1 0x3C with stop bit 0, then break for 40 ticks
    dc = done_cnt;
    expect_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 40 * 16);
    chk("break_single_done", done_cnt, dc + 1);
    check_frame("f8n1_break");
    hold(1'b1, 2 * BitClks);
    chk("break_no_extra", done_cnt, dc + 1);

    // False start
    dc = done_cnt;
    ar = active_rises;
    hold(1'b0, 4 * 16);
    hold(1'b1, 2 * BitClks);
    chk("false_no_done", done_cnt, dc);
    chk("false_no_active", active_rises, ar);
    chk("false_data_held", data_out, 8'h3C);
    chk("false_perr_held", parity_error, 0);
    chk("false_ferr_held", frame_error, 1);

    // Reset in the 4th data bit of an 8N1 frame
    dc = done_cnt;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    data_length = 1'b1;
    hold(1'b0, BitClks);
    hold(1'b1, BitClks);
    hold(1'b0, BitClks);
    hold(1'b1, BitClks);
    hold(1'b1, BitClks / 2);
    chk("mid_active_before_rst", rx_active, 1);
    rst = 1'b1;
    @(negedge clock);
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_active", rx_active, 0);
    chk("mid_rst_done", rx_done, 0);
    chk("mid_rst_perr", parity_error, 0);
    chk("mid_rst_ferr", frame_error, 0);
    rst = 1'b0;
    hold(1'b1, 3 * BitClks);
    chk("mid_rst_no_done", done_cnt, dc);

    expect_frame(8'h81, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    send(8'h81, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    check_frame("f8n1_81");
    hold(1'b1, BitClks);

    chk("done_one_clock", done_wide, 0);
    chk("sb_drained", sb.size(), 0);
    chk("obs_drained", obs.size(), 0);
    chk("done_total", done_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-in, parallel-out receive shift register for the UART receive path: the counterpart of the transmit-side parallel-in, serial-out frame register. It detects a start bit on the serial line using a 16x oversampling tick and samples each bit at its centre. It deserializes LSB-first data of 7 or 8 bits, checks optional odd/even parity and one or two stop bits, and presents the received word with a one-cycle done pulse and error flags. It sits between the baud-rate generator (16x tick) and the UART receive controller.

## Interface
- OVERSAMPLE, 16, sample ticks per bit period; fixed at 16 for this revision.
- clock  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-clock-wide enable at 16x baud rate.
- data_in  in  1  serial line; idle high; passes through an internal 2-flop synchronizer.
- parity_type  in  2  01 = odd, 10 = even, 00/11 = no parity bit.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- data_length  in  1  0 = 7 data bits, 1 = 8 data bits.
- data_out  out  8  received word, LSB = first data bit; bit 7 is 0 for 7-bit frames.
- rx_active  out  1  high while a frame is being received.
- rx_done  out  1  one-clock pulse when a frame completes.
- parity_error  out  1  parity mismatch on the last frame; valid with rx_done and held until the next rx_done.
- frame_error  out  1  a stop bit was sampled 0 on the last frame; valid and held like parity_error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. Only sample_tick cycles advance the tick counter (0..15); other clocks hold it.
- IDLE is armed only after the synchronized line is sampled high on a tick. While armed, a tick that samples 0 enters START with the tick counter cleared.
- On entry to START, latch parity_type, stop_bits and data_length. Mid-frame changes to these inputs are ignored.
- START: on the 8th tick after entry (bit centre), sample the line.
  - 0: go to DATA with the counter cleared and rx_active set.
  - 1: false start; return to IDLE (armed) with no rx_done and no flag change.
- DATA: every 16th tick, shift the sampled bit in LSB-first.
  - After 7 or 8 bits, go to PARITY if parity is enabled, otherwise to STOP.
  - 7-bit frames are right-aligned, with data_out[7] = 0.
- PARITY: every 16th tick, sample the parity bit.
  - Odd: data bits plus parity bit must contain an odd number of ones.
  - Even: they must contain an even number of ones.
  - A mismatch sets the internal parity-error flag.
- STOP: sample one or two stop bits, 16 ticks apart. Any stop bit sampled 0 sets the internal frame-error flag. After the last stop bit, go to DONE.
- DONE: lasts one clock and is not tick-gated. In that cycle:
  - Update data_out, parity_error and frame_error.
  - Pulse rx_done.
  - Clear rx_active.
  - Return to IDLE.
- After DONE, IDLE re-arms only once the line is sampled high. A line held low (break) therefore produces exactly one frame_error frame and no back-to-back frames.

## Timing
- Reset values: data_out = 8'h00, rx_active = 0, rx_done = 0, parity_error = 0, frame_error = 0. State = IDLE, unarmed.
- Synchronizer latency: 2 clocks from data_in to the sampled line.
- Ticks from start-bit detection to the final stop-bit sample: 8 + 16 × (data bits + parity bit + stop bits).
  - 8N1 = 8 + 16 × 9 = 152 ticks.
  - 7E2 = 8 + 16 × 10 = 168 ticks.
- rx_done rises on the clock edge after the tick that samples the final stop bit, and lasts exactly 1 clock.
- rx_active rises on the clock edge after the START centre sample, and falls together with the rx_done pulse.
- Outputs are not updated on a false start.
- rst asserted mid-frame: on the next clock edge, all outputs and state return to reset values. No rx_done is produced.
- rst has priority over sample_tick when both are asserted in the same cycle.
- data_out, parity_error and frame_error hold their values between frames.

## Test plan
- 8N1 frame carrying 0xA5 at 16 clocks per tick -> one rx_done pulse, data_out = 8'hA5, parity_error = 0, frame_error = 0, rx_active high for 144 ticks.
- 8O1 frame with 0x4A and parity bit 1 (correct bit is 0) -> data_out = 8'h4A, parity_error = 1; resend with parity bit 0 -> parity_error = 0.
- 7E2 frame with 0x55 and parity bit 0 -> data_out = 8'h55 (bit 7 = 0), no errors; rx_done occurs 168 ticks after start detection.
- 8N1 frame with 0x3C and the stop bit forced 0, then the line held low for 40 ticks -> data_out = 8'h3C, frame_error = 1, no second frame until the line returns high.
- False start (line low for 4 ticks, then high) -> no rx_active, no rx_done; outputs unchanged from the previous frame.
- rst pulsed 1 clock during the 4th data bit of an 8N1 frame -> all outputs 0 on the next edge, no rx_done; a following 0x81 frame is received correctly.
